// File: rtl/ttl_stim_gen.sv
// ttl_stim_gen
// Multi-channel TTL stimulus generator. Every channel runs its own pulse
// train: an initial DELAY, then COUNT pulses of WIDTH high cycles spaced
// PERIOD cycles rising-to-rising. All channels start together on arm_i.
// A channel ends on the last high cycle of its last pulse; the trailing low
// phase is not emitted.
//
// Ports
//   FCLK       : clock, rising edge
//   ARESETn    : asynchronous active-low reset
//   wr_i       : register write strobe
//   wr_addr_i  : {channel[3:0], reg[1:0]}; reg 0=DELAY 1=WIDTH 2=PERIOD 3=COUNT
//   wr_data_i  : register write data
//   arm_i      : start pulse for all channels (ignored while busy_o is high)
//   disarm_i   : abort pulse, wins over arm_i
//   ttl_o      : registered stimulus outputs, one bit per channel
//   busy_o     : high while any channel is running
//   done_o     : one-cycle pulse on normal completion of all channels
//
// Optional feature: define TTL_STIM_GEN_POLARITY_EN to turn address 6'h3F
// (channel 15, reg 3) into a NUM_CH-bit polarity mask XORed onto ttl_o.
// Without the macro, writes to that address are dropped.
module ttl_stim_gen #(
  parameter int NUM_CH = 6,
  parameter int CNT_W  = 32
) (
  input  logic              FCLK,
  input  logic              ARESETn,
  input  logic              wr_i,
  input  logic [5:0]        wr_addr_i,
  input  logic [CNT_W-1:0]  wr_data_i,
  input  logic              arm_i,
  input  logic              disarm_i,
  output logic [NUM_CH-1:0] ttl_o,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DELAY = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_FIN   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

  // Low-phase length from the programmed WIDTH/PERIOD. PERIOD <= WIDTH
  // stretches the period to WIDTH+1; WIDTH=0 gives all-low periods of
  // max(PERIOD,1). The all-ones WIDTH case wraps to a low length of 1.
  function automatic logic [CNT_W-1:0] low_len(input logic [CNT_W-1:0] width,
                                               input logic [CNT_W-1:0] period);
    logic [CNT_W-1:0] eff;
    if (width == '0) begin
      eff = (period == '0) ? ONE : period;
    end else if (period <= width) begin
      eff = width + ONE;
    end else begin
      eff = period;
    end
    return eff - width;
  endfunction

  logic [CNT_W-1:0]  delay_r  [NUM_CH];
  logic [CNT_W-1:0]  width_r  [NUM_CH];
  logic [CNT_W-1:0]  period_r [NUM_CH];
  logic [CNT_W-1:0]  count_r  [NUM_CH];
  logic              pol_addr_s;
  logic              cfg_we_s;
  logic              arm_ok_s;
  logic              busy_r, busy_s;
  logic              done_r, done_s;
  logic [NUM_CH-1:0] raw_s;
  logic [NUM_CH-1:0] active_s;
  logic [NUM_CH-1:0] pol_s;
  logic [NUM_CH-1:0] ttl_r;

  assign pol_addr_s = (wr_addr_i == 6'h3F);
  assign cfg_we_s   = wr_i & ~pol_addr_s;
  assign arm_ok_s   = arm_i & ~disarm_i & ~busy_r;

  // Programmable per-channel timing registers; channels >= NUM_CH never match.
  always_ff @(posedge FCLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int c = 0; c < NUM_CH; c++) begin
        delay_r[c]  <= '0;
        width_r[c]  <= ONE;
        period_r[c] <= TWO;
        count_r[c]  <= ONE;
      end
    end else if (cfg_we_s) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (wr_addr_i[5:2] == 4'(c)) begin
          case (wr_addr_i[1:0])
            2'd0:    delay_r[c]  <= wr_data_i;
            2'd1:    width_r[c]  <= wr_data_i;
            2'd2:    period_r[c] <= wr_data_i;
            2'd3:    count_r[c]  <= wr_data_i;
            default: delay_r[c]  <= delay_r[c];
          endcase
        end
      end
    end
  end

`ifdef TTL_STIM_GEN_POLARITY_EN
  logic [NUM_CH-1:0] pol_r;

  // Output polarity mask.
  always_ff @(posedge FCLK or negedge ARESETn) begin
    if (!ARESETn) begin
      pol_r <= '0;
    end else if (wr_i && pol_addr_s) begin
      pol_r <= wr_data_i[NUM_CH-1:0];
    end
  end

  assign pol_s = pol_r;
`else
  assign pol_s = '0;
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;    // phase down-counter
    logic [CNT_W-1:0] pcnt_r, pcnt_s;  // pulses remaining
    logic [CNT_W-1:0] wid_r, wid_s;    // shadow WIDTH
    logic [CNT_W-1:0] low_r, low_s;    // shadow low-phase length
    logic             free_r, free_s;  // COUNT was 0 at arm

    // Channel next-state logic; a phase ends when its counter is already 0.
    always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      pcnt_s  = pcnt_r;
      wid_s   = wid_r;
      low_s   = low_r;
      free_s  = free_r;
      if (disarm_i) begin
        state_s = ST_IDLE;
        cnt_s   = '0;
        pcnt_s  = '0;
      end else if (arm_ok_s) begin
        state_s = ST_DELAY;
        cnt_s   = delay_r[g];
        pcnt_s  = count_r[g];
        wid_s   = width_r[g];
        low_s   = low_len(width_r[g], period_r[g]);
        free_s  = (count_r[g] == '0);
      end else begin
        case (state_r)
          ST_DELAY: begin
            if (cnt_r != '0) begin
              cnt_s = cnt_r - ONE;
            end else if (wid_r != '0) begin
              state_s = ST_HIGH;
              cnt_s   = wid_r - ONE;
            end else begin
              state_s = ST_LOW;
              cnt_s   = low_r - ONE;
            end
          end
          ST_HIGH: begin
            if (cnt_r != '0) begin
              cnt_s = cnt_r - ONE;
            end else if (!free_r && (pcnt_r == ONE)) begin
              state_s = ST_FIN;
              pcnt_s  = '0;
            end else begin
              state_s = ST_LOW;
              cnt_s   = low_r - ONE;
              pcnt_s  = free_r ? pcnt_r : (pcnt_r - ONE);
            end
          end
          ST_LOW: begin
            if (cnt_r != '0) begin
              cnt_s = cnt_r - ONE;
            end else if (wid_r != '0) begin
              state_s = ST_HIGH;
              cnt_s   = wid_r - ONE;
            end else if (!free_r && (pcnt_r == ONE)) begin
              // zero-width train: a period is counted when its low phase ends
              state_s = ST_FIN;
              pcnt_s  = '0;
            end else begin
              cnt_s  = low_r - ONE;
              pcnt_s = free_r ? pcnt_r : (pcnt_r - ONE);
            end
          end
          ST_FIN: begin
            if (!busy_r) begin
              state_s = ST_IDLE;
            end else begin
              state_s = ST_FIN;
            end
          end
          ST_IDLE: state_s = ST_IDLE;
          default: state_s = ST_IDLE;
        endcase
      end
    end

    // Channel state and counter registers.
    always_ff @(posedge FCLK or negedge ARESETn) begin
      if (!ARESETn) begin
        state_r <= ST_IDLE;
        cnt_r   <= '0;
        pcnt_r  <= '0;
        wid_r   <= '0;
        low_r   <= '0;
        free_r  <= 1'b0;
      end else begin
        state_r <= state_s;
        cnt_r   <= cnt_s;
        pcnt_r  <= pcnt_s;
        wid_r   <= wid_s;
        low_r   <= low_s;
        free_r  <= free_s;
      end
    end

    assign raw_s[g]    = (state_s == ST_HIGH);
    assign active_s[g] = (state_s == ST_DELAY) || (state_s == ST_HIGH) || (state_s == ST_LOW);
  end

  // Global busy/done; done only when the run drains without a disarm.
  always_comb begin
    busy_s = busy_r;
    done_s = 1'b0;
    if (disarm_i) begin
      busy_s = 1'b0;
    end else if (arm_ok_s) begin
      busy_s = 1'b1;
    end else if (busy_r) begin
      busy_s = |active_s;
      done_s = ~(|active_s);
    end else begin
      busy_s = 1'b0;
    end
  end

  // Output registers.
  always_ff @(posedge FCLK or negedge ARESETn) begin
    if (!ARESETn) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
      ttl_r  <= '0;
    end else begin
      busy_r <= busy_s;
      done_r <= done_s;
      ttl_r  <= raw_s ^ pol_s;
    end
  end

  assign ttl_o  = ttl_r;
  assign busy_o = busy_r;
  assign done_o = done_r;

endmodule

// File: tb/tb_ttl_stim_gen.sv
// Scoreboard bench for ttl_stim_gen: stimulus pushes per-cycle expected
// {ttl, busy, done} tagged with an absolute cycle number; the monitor pops
// and compares at each falling edge.
module tb_ttl_stim_gen;

  logic        FCLK;
  logic        ARESETn;
  logic        wr_i;
  logic [5:0]  wr_addr_i;
  logic [31:0] wr_data_i;
  logic        arm_i;
  logic        disarm_i;
  logic [5:0]  ttl_o;
  logic        busy_o;
  logic        done_o;

  ttl_stim_gen #(.NUM_CH(6), .CNT_W(32)) dut (
    .FCLK      (FCLK),
    .ARESETn   (ARESETn),
    .wr_i      (wr_i),
    .wr_addr_i (wr_addr_i),
    .wr_data_i (wr_data_i),
    .arm_i     (arm_i),
    .disarm_i  (disarm_i),
    .ttl_o     (ttl_o),
    .busy_o    (busy_o),
    .done_o    (done_o)
  );

  typedef struct {
    int         cyc;
    logic [5:0] ttl;
    logic       busy;
    logic       done;
    int         tid;
    int         k;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  bit   stim_done = 1'b0;
  int   b;
  int   b0;
  logic [5:0] pm;

  initial FCLK = 1'b0;
  always #5 FCLK = ~FCLK;

  always @(posedge FCLK) cyc <= cyc + 1;

  task automatic push(input int base, input int from, input int to, input logic [5:0] t,
                      input logic bz, input logic dn, input int tid);
    for (int k = from; k <= to; k++) begin
      exp_q.push_back('{cyc: base + k, ttl: t, busy: bz, done: dn, tid: tid, k: k});
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge FCLK);
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    @(negedge FCLK);
    wr_i = 1'b1;
    wr_addr_i = a;
    wr_data_i = d;
    @(negedge FCLK);
    wr_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge FCLK);
    ARESETn = 1'b0;
    @(negedge FCLK);
    ARESETn = 1'b1;
  endtask

  // Starts an arm pulse; returns the absolute cycle of the arm sampling edge.
  task automatic arm_begin(output int base);
    @(negedge FCLK);
    base = cyc + 1;
    arm_i = 1'b1;
  endtask

  task automatic arm_end();
    @(negedge FCLK);
    arm_i = 1'b0;
    disarm_i = 1'b0;
  endtask

  // Monitor / scoreboard.
  initial begin
    exp_t e;
    int   drain;
    bit   run;
    drain = 0;
    run = 1'b1;
    while (run) begin
      @(negedge FCLK);
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (e.cyc != cyc || ttl_o !== e.ttl || busy_o !== e.busy || done_o !== e.done) begin
          n_fail++;
          $display("FAIL T%0d.c%0d (abs %0d): got ttl=%b busy=%b done=%b, want ttl=%b busy=%b done=%b",
                   e.tid, e.k, cyc, ttl_o, busy_o, done_o, e.ttl, e.busy, e.done);
        end
      end
      if (cyc > 20000) begin
        n_cmp++;
        n_fail++;
        $display("FAIL timeout: got cycle %0d, want stimulus finished before 20000", cyc);
        run = 1'b0;
      end else if (stim_done) begin
        if (exp_q.size() == 0) begin
          run = 1'b0;
        end else begin
          drain++;
          if (drain > 200) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: got %0d expectations unchecked, want 0", exp_q.size());
            run = 1'b0;
          end
        end
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Directed stimulus.
  initial begin
`ifdef TTL_STIM_GEN_POLARITY_EN
    pm = 6'b000001;
`else
    pm = 6'b000000;
`endif
    ARESETn   = 1'b0;
    wr_i      = 1'b0;
    wr_addr_i = 6'd0;
    wr_data_i = 32'd0;
    arm_i     = 1'b0;
    disarm_i  = 1'b0;

    // T0: reset state and idle after release
    push(0, 1, 6, 6'b000000, 1'b0, 1'b0, 0);
    wait_cyc(3);
    ARESETn = 1'b1;
    wait_cyc(6);

    // T1: ch0 DELAY=3 WIDTH=2 PERIOD=5 COUNT=3; others default (pulse at cycle 1)
    wr(6'd0, 32'd3);
    wr(6'd1, 32'd2);
    wr(6'd2, 32'd5);
    wr(6'd3, 32'd3);
    arm_begin(b);
    push(b, 0, 0, 6'b000000, 1'b1, 1'b0, 1);
    push(b, 1, 1, 6'b111110, 1'b1, 1'b0, 1);
    push(b, 2, 3, 6'b000000, 1'b1, 1'b0, 1);
    push(b, 4, 5, 6'b000001, 1'b1, 1'b0, 1);
    push(b, 6, 8, 6'b000000, 1'b1, 1'b0, 1);
    push(b, 9, 10, 6'b000001, 1'b1, 1'b0, 1);
    push(b, 11, 13, 6'b000000, 1'b1, 1'b0, 1);
    push(b, 14, 15, 6'b000001, 1'b1, 1'b0, 1);
    push(b, 16, 16, 6'b000000, 1'b0, 1'b1, 1);
    push(b, 17, 18, 6'b000000, 1'b0, 1'b0, 1);
    arm_end();
    wait_cyc(b + 18);

    // T2: ch1 WIDTH=4 PERIOD=2 COUNT=2 -> period 5
    do_reset();
    wr(6'd5, 32'd4);
    wr(6'd6, 32'd2);
    wr(6'd7, 32'd2);
    arm_begin(b);
    push(b, 0, 0, 6'b000000, 1'b1, 1'b0, 2);
    push(b, 1, 1, 6'b111111, 1'b1, 1'b0, 2);
    push(b, 2, 4, 6'b000010, 1'b1, 1'b0, 2);
    push(b, 5, 5, 6'b000000, 1'b1, 1'b0, 2);
    push(b, 6, 9, 6'b000010, 1'b1, 1'b0, 2);
    push(b, 10, 10, 6'b000000, 1'b0, 1'b1, 2);
    push(b, 11, 11, 6'b000000, 1'b0, 1'b0, 2);
    arm_end();
    wait_cyc(b + 11);

    // T3: ch2 free-running; mid-run write and re-arm ignored; disarm at 50
    do_reset();
    wr(6'd11, 32'd0);
    arm_begin(b);
    push(b, 0, 0, 6'b000000, 1'b1, 1'b0, 3);
    push(b, 1, 1, 6'b111111, 1'b1, 1'b0, 3);
    for (int k = 2; k <= 50; k++) begin
      push(b, k, k, ((k % 2) == 1) ? 6'b000100 : 6'b000000, 1'b1, 1'b0, 3);
    end
    push(b, 51, 53, 6'b000000, 1'b0, 1'b0, 3);
    arm_end();
    wait_cyc(b + 9);
    wr(6'd9, 32'd3);
    wait_cyc(b + 18);
    @(negedge FCLK);
    arm_i = 1'b1;
    @(negedge FCLK);
    arm_i = 1'b0;
    wait_cyc(b + 49);
    @(negedge FCLK);
    disarm_i = 1'b1;
    @(negedge FCLK);
    disarm_i = 1'b0;
    wait_cyc(b + 53);

    // T4: arm and disarm together from IDLE -> nothing starts
    arm_begin(b);
    disarm_i = 1'b1;
    push(b, 0, 5, 6'b000000, 1'b0, 1'b0, 4);
    arm_end();
    wait_cyc(b + 5);

    // T5: async reset mid-pulse, then defaults on re-arm
    do_reset();
    wr(6'd1, 32'd6);
    wr(6'd2, 32'd8);
    arm_begin(b);
    push(b, 0, 0, 6'b000000, 1'b1, 1'b0, 5);
    push(b, 1, 1, 6'b111111, 1'b1, 1'b0, 5);
    push(b, 2, 2, 6'b000001, 1'b1, 1'b0, 5);
    push(b, 3, 4, 6'b000000, 1'b0, 1'b0, 5);
    arm_end();
    wait_cyc(b + 2);
    @(posedge FCLK);
    #1;
    ARESETn = 1'b0;
    wait_cyc(b + 4);
    push(b, 5, 8, 6'b000000, 1'b0, 1'b0, 5);
    ARESETn = 1'b1;
    wait_cyc(b + 8);
    arm_begin(b);
    push(b, 0, 0, 6'b000000, 1'b1, 1'b0, 6);
    push(b, 1, 1, 6'b111111, 1'b1, 1'b0, 6);
    push(b, 2, 2, 6'b000000, 1'b0, 1'b1, 6);
    push(b, 3, 4, 6'b000000, 1'b0, 1'b0, 6);
    arm_end();
    wait_cyc(b + 4);

    // T7: ch3 WIDTH=0 PERIOD=3 COUNT=2 -> stays low, two 3-cycle periods
    wr(6'd13, 32'd0);
    wr(6'd14, 32'd3);
    wr(6'd15, 32'd2);
    arm_begin(b);
    push(b, 0, 0, 6'b000000, 1'b1, 1'b0, 7);
    push(b, 1, 1, 6'b110111, 1'b1, 1'b0, 7);
    push(b, 2, 6, 6'b000000, 1'b1, 1'b0, 7);
    push(b, 7, 7, 6'b000000, 1'b0, 1'b1, 7);
    push(b, 8, 8, 6'b000000, 1'b0, 1'b0, 7);
    arm_end();
    wait_cyc(b + 8);

    // T8: polarity write (effective only with the polarity macro)
    do_reset();
    wr(6'h3F, 32'd1);
    b0 = cyc;
    push(b0, 2, 3, pm, 1'b0, 1'b0, 8);
    wait_cyc(b0 + 3);
    arm_begin(b);
    push(b, 0, 0, pm, 1'b1, 1'b0, 8);
    push(b, 1, 1, 6'b111111 ^ pm, 1'b1, 1'b0, 8);
    push(b, 2, 2, pm, 1'b0, 1'b1, 8);
    push(b, 3, 4, pm, 1'b0, 1'b0, 8);
    arm_end();
    wait_cyc(b + 4);

    stim_done = 1'b1;
  end

endmodule

// File: doc/ttl_stim_gen.md
TTL_STIM_GEN -- requirements
Module: ttl_stim_gen

Interface
REQ-001 Parameter NUM_CH, default 6, number of independent TTL stimulus channels (1..16).
REQ-002 Parameter CNT_W, default 32, width of delay/width/period/count registers.
REQ-003 FCLK  input  1  sole clock; all logic on rising edge.
REQ-004 ARESETn  input  1  asynchronous active-low reset.
REQ-005 wr_i  input  1  register write strobe, one write per cycle.
REQ-006 wr_addr_i  input  6  {channel[3:0], reg[1:0]}; reg 0=DELAY, 1=WIDTH, 2=PERIOD, 3=COUNT.
REQ-007 wr_data_i  input  CNT_W  register write data.
REQ-008 arm_i  input  1  single-cycle start pulse for all channels.
REQ-009 disarm_i  input  1  single-cycle abort pulse.
REQ-010 ttl_o  output  NUM_CH  registered stimulus outputs, one bit per channel.
REQ-011 busy_o  output  1  high while any channel is running.
REQ-012 done_o  output  1  one-cycle pulse on normal completion of all channels.

Function
REQ-013 Each channel SHALL hold DELAY, WIDTH, PERIOD, COUNT registers; writes to channel >= NUM_CH SHALL be ignored.
REQ-014 Register writes SHALL be accepted at any time; running channels SHALL use shadow copies latched on the arm cycle.
REQ-015 Per-channel FSM states: IDLE, DELAY, HIGH, LOW, FIN.
REQ-016 arm_i sampled high in IDLE with busy_o low SHALL latch shadows and move every channel to DELAY; arm_i while busy_o high SHALL be ignored.
REQ-017 ttl_o[c] SHALL rise DELAY+1 cycles after the arm sampling edge (DELAY=0 -> rises the cycle after arm).
REQ-018 HIGH SHALL last WIDTH cycles; LOW SHALL last PERIOD-WIDTH cycles; rising-to-rising spacing = PERIOD.
REQ-019 PERIOD <= WIDTH SHALL be treated as PERIOD = WIDTH+1 (minimum one low cycle).
REQ-020 WIDTH = 0 SHALL keep ttl_o[c] low while the channel still steps through COUNT periods of length max(PERIOD,1).
REQ-021 COUNT pulses SHALL be emitted, then the channel enters FIN with ttl_o[c] low; COUNT = 0 SHALL mean free-running until disarm.
REQ-022 Counters SHALL be CNT_W-bit down-counters, no wrap: a counter at 0 terminates its state.
REQ-023 busy_o SHALL rise the cycle after arm is accepted and fall the cycle after the last finite channel reaches FIN.
REQ-024 done_o SHALL pulse for one cycle coincident with busy_o falling on normal completion; free-running channels never complete, so done_o is not produced while any is active.
REQ-025 disarm_i SHALL return all channels to IDLE, drive ttl_o to 0 and busy_o to 0 on the next cycle, without a done_o pulse.
REQ-026 arm_i and disarm_i in the same cycle: disarm wins, no arm.
REQ-027 FIN channels SHALL return to IDLE when busy_o falls.

Reset
REQ-028 ARESETn low SHALL immediately force ttl_o=0, busy_o=0, done_o=0, all FSMs IDLE, all counters 0.
REQ-029 Register contents SHALL reset to DELAY=0, WIDTH=1, PERIOD=2, COUNT=1.
REQ-030 Reset mid-run SHALL abort silently; release SHALL not restart stimulus without a new arm_i.

Configuration
REQ-031 Macro TTL_STIM_GEN_POLARITY_EN defined: reg address 3 of channel 15 SHALL be a NUM_CH-bit POLARITY mask (reset 0); ttl_o = raw XOR mask, including in IDLE/FIN and reset-released states.
REQ-032 Macro undefined: no polarity register, writes to that address ignored, ttl_o active-high, idle-low.

Verification
REQ-033 Ch0 DELAY=3 WIDTH=2 PERIOD=5 COUNT=3, arm -> ttl_o[0] high cycles 4-5, 9-10, 14-15 after arm; done_o at cycle 16.
REQ-034 Ch1 WIDTH=4 PERIOD=2 COUNT=2 -> effective period 5: high 4, low 1, two pulses then done_o.
REQ-035 Ch2 COUNT=0 free-running, disarm at cycle 50 -> ttl_o 0 and busy_o 0 at cycle 51, no done_o.
REQ-036 arm_i and disarm_i same cycle from IDLE -> busy_o stays 0, ttl_o stays 0; arm while busy -> timing unchanged.
REQ-037 ARESETn low mid-pulse -> ttl_o 0 asynchronously; after release, registers read back reset defaults by reproducing REQ-029 waveform on arm.
REQ-038 With TTL_STIM_GEN_POLARITY_EN, mask 6'b000001 -> ttl_o[0]=1 at idle, pulses active-low; without macro same write has no effect.
